// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the sum accumulator: state encoding, counter sizing
// and the adder-stage sum width.
package sum_acc_pkg;

  localparam int unsigned ADDER_W   = 4;
  localparam int unsigned SUM_W_DEF = ADDER_W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Sample counter width; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sum_acc_datapath.sv
// Accumulator register with carry detection, sticky overflow and wrap/saturate select.
// Saturation is enabled by defining ACC_SATURATE_EN; otherwise the total wraps.
module sum_acc_datapath
  import sum_acc_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned ACC_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add_en,
  input  logic [SUM_W-1:0] sum,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int unsigned EXT_W = ACC_W + 1;

  logic [EXT_W-1:0] addend_c;
  logic [EXT_W-1:0] total_c;
  logic             carry_c;
  logic [ACC_W-1:0] acc_next_c;

  // Gate the addend so an undriven sum cannot reach the adder while idle
  always_comb begin
    addend_c = '0;
    if (add_en) begin
      addend_c = EXT_W'(sum);
    end
    total_c = EXT_W'(acc) + addend_c;
    carry_c = total_c[ACC_W];
`ifdef ACC_SATURATE_EN
    acc_next_c = carry_c ? '1 : total_c[ACC_W-1:0];
`else
    acc_next_c = total_c[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= acc_next_c;
      ovf <= ovf | carry_c;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES adder sums per block and presents the total over a
// valid/ready handshake. Optional ACC_SATURATE_EN clamps instead of wrapping.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned SUM_W       = SUM_W_DEF,
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned ACC_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = cnt_width(NUM_SAMPLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;
  logic             release_c;
  logic             cnt_last_c;

  assign accept_c   = in_valid & in_ready;
  assign release_c  = out_valid & out_ready;
  assign cnt_last_c = (cnt == CNT_W'(NUM_SAMPLES - 1));

  // Block FSM with sample counter; handshake outputs are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept_c) begin
            if (cnt_last_c) begin
              state     <= HOLD;
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // Input reopens only the cycle after the total is taken
          if (release_c) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  sum_acc_datapath #(
    .SUM_W (SUM_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (release_c),
    .add_en (accept_c),
    .sum    (in_sum),
    .acc    (out_acc),
    .ovf    (out_ovf)
  );

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator (default ACC_W=7 plus an ACC_W=6 instance);
// expected 6-bit totals follow ACC_SATURATE_EN when it is defined.
module tb_sum_accumulator;

`ifdef ACC_SATURATE_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [0:3][4:0] s;
    logic [6:0]      acc7;
    logic            ovf7;
    logic [5:0]      wrap6;
    logic [5:0]      sat6;
    logic            ovf6;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] in_sum = '0;

  logic       in_ready, out_valid, out_ovf;
  logic [6:0] out_acc;
  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_acc6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  sum_accumulator #(.ACC_W(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .in_sum    (in_sum),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .out_acc   (out_acc6),
    .out_ovf   (out_ovf6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [4:0] s);
    in_valid = 1'b1;
    in_sum   = s;
    tick();
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int acc7, input int ovf7, input int wrap6,
                              input int sat6, input int ovf6);
    vec_t v;
    v.s[0]  = 5'(a);
    v.s[1]  = 5'(b);
    v.s[2]  = 5'(c);
    v.s[3]  = 5'(d);
    v.acc7  = 7'(acc7);
    v.ovf7  = 1'(ovf7);
    v.wrap6 = 6'(wrap6);
    v.sat6  = 6'(sat6);
    v.ovf6  = 1'(ovf6);
    return v;
  endfunction

  vec_t vecs[8];
  bit   pat[7];

  initial begin
    vecs[0] = mk(3, 5, 7, 9,     24, 0, 24, 24, 0);
    vecs[1] = mk(31, 31, 31, 31, 124, 0, 60, 63, 1);
    vecs[2] = mk(0, 0, 0, 0,     0, 0, 0, 0, 0);
    vecs[3] = mk(1, 2, 3, 4,     10, 0, 10, 10, 0);
    vecs[4] = mk(16, 16, 16, 16, 64, 0, 0, 63, 1);
    vecs[5] = mk(31, 31, 2, 1,   65, 0, 1, 63, 1);
    vecs[6] = mk(20, 10, 1, 1,   32, 0, 32, 32, 0);
    vecs[7] = mk(31, 31, 1, 0,   63, 0, 63, 63, 0);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 1);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_acc", 32'(out_acc), 0);
    check("rst out_ovf", 32'(out_ovf), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Back-to-back blocks, total released immediately
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) feed(vecs[i].s[k]);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 0);
      check($sformatf("v%0d out_acc", i), 32'(out_acc), 32'(vecs[i].acc7));
      check($sformatf("v%0d out_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf7));
      check($sformatf("v%0d acc6", i), 32'(out_acc6),
            SAT_BUILD ? 32'(vecs[i].sat6) : 32'(vecs[i].wrap6));
      check($sformatf("v%0d ovf6", i), 32'(out_ovf6), 32'(vecs[i].ovf6));
      in_valid = 1'b1;
      in_sum   = 5'd31;
      tick();
      check($sformatf("v%0d rel out_valid", i), 32'(out_valid), 0);
      check($sformatf("v%0d rel in_ready", i), 32'(in_ready), 1);
      in_valid = 1'b0;
    end

    // Backpressure: total held, nothing consumed while out_ready is low
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) feed(5'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_sum   = 5'd7;
      tick();
      check($sformatf("bp%0d out_valid", c), 32'(out_valid), 1);
      check($sformatf("bp%0d in_ready", c), 32'(in_ready), 0);
      check($sformatf("bp%0d out_acc", c), 32'(out_acc), 4);
    end
    out_ready = 1'b1;
    tick();
    check("bp rel out_valid", 32'(out_valid), 0);
    for (int k = 0; k < 4; k++) feed(5'd2);
    check("bp next out_valid", 32'(out_valid), 1);
    check("bp next out_acc", 32'(out_acc), 8);
    in_valid = 1'b0;
    tick();

    // Gapped input with undriven sum on idle cycles
    begin
      int n = 1;
      for (int j = 0; j < 7; j++) begin
        if (pat[j]) begin
          in_valid = 1'b1;
          in_sum   = 5'(n);
          n++;
        end else begin
          in_valid = 1'b0;
          in_sum   = 'x;
        end
        tick();
        if (j == 5) check("gap early out_valid", 32'(out_valid), 0);
      end
    end
    check("gap out_valid", 32'(out_valid), 1);
    check("gap out_acc", 32'(out_acc), 10);
    in_valid = 1'b0;
    in_sum   = '0;
    tick();

    // Asynchronous reset mid-block discards the partial sum
    feed(5'd5);
    feed(5'd5);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_acc", 32'(out_acc), 0);
    check("mid rst in_ready", 32'(in_ready), 1);
    check("mid rst out_valid", 32'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) feed(5'd2);
    check("post rst out_valid", 32'(out_valid), 1);
    check("post rst out_acc", 32'(out_acc), 8);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while holding a total
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) feed(5'd3);
    in_valid = 1'b0;
    check("hold out_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("hold rst out_valid", 32'(out_valid), 0);
    check("hold rst out_acc", 32'(out_acc), 0);
    check("hold rst in_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) feed(5'd4);
    check("hold post out_acc", 32'(out_acc), 16);
    check("hold post out_ovf", 32'(out_ovf), 0);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream consumer of the 4-bit adder's 5-bit sum output. It accepts a stream of sums over a valid/ready handshake and accumulates NUM_SAMPLES of them into one block total. It then presents the total over a second valid/ready handshake. It is the first sequential stage after the combinational adder tree and registers the adder result for the rest of the datapath.

Parameters:
SUM_W, 5, width of incoming sum (matches adder output width 4+1)
NUM_SAMPLES, 4, sums accumulated per block; legal range 2..256
ACC_W, 7, accumulator/output width; default holds 4*31=124 without overflow

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sum valid
in_ready  output  1  block can accept a sum this cycle
in_sum  input  SUM_W  unsigned sum from adder stage
out_valid  output  1  block total valid
out_ready  input  1  downstream accepts total
out_acc  output  ACC_W  accumulated block total, unsigned
out_ovf  output  1  total exceeded ACC_W range during this block

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-block):
  - state=ACCUM, acc=0, cnt=0, ovf=0
  - outputs: in_ready=1, out_valid=0, out_acc=0, out_ovf=0
  - any partial block is discarded.
- Interface ownership: clk and rst_n are the only clock/reset; all state regs use async active-low reset.
- State machine, two states (ACCUM, HOLD):
  - ACCUM:
    - in_ready=1, out_valid=0.
    - Accept = in_valid & in_ready. On accept: acc <= acc + zero-extended in_sum; cnt <= cnt+1.
    - On the accept where cnt==NUM_SAMPLES-1: go to HOLD, cnt <= 0.
  - HOLD:
    - in_ready=0, out_valid=1, out_acc=acc, out_ovf=ovf. All are stable until the output handshake.
    - On out_valid & out_ready: acc <= 0, ovf <= 0, go to ACCUM.
    - in_ready stays 0 in that same cycle (no same-cycle output release and input accept). Next accept is at the earliest the following cycle.
- Latency: out_valid rises the cycle after the NUM_SAMPLES-th accept. Throughput is 1 sum/cycle in ACCUM, with one bubble cycle per block minimum.
- Arithmetic:
  - Unsigned addition computed at ACC_W+1 bits.
  - Carry-out into bit ACC_W sets sticky ovf for the block.
  - Without the optional feature, acc keeps the low ACC_W bits (wrap).
- in_sum is ignored when in_valid=0. in_valid may toggle freely; gaps do not affect cnt.
- Counter width is $clog2(NUM_SAMPLES). No wrap-around beyond NUM_SAMPLES-1.
- X on in_sum while in_valid=0 must not propagate to acc.

Optional Feature:
ACC_SATURATE_EN:
- Defined: on overflow, acc clamps to all-ones (2^ACC_W-1), ovf is set, and further adds keep the clamp.
- Undefined: acc wraps modulo 2^ACC_W, ovf is still set.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package sum_acc_pkg:
  - state enum typedef {ACCUM, HOLD}
  - function computing counter width
  - localparam default SUM_W=5 tied to the adder width.
- One natural sub-module: sum_acc_datapath.
  - Contents: acc register, add with carry, wrap/saturate select, ovf flag.
  - Controls: clear and add-enable, driven by the top-level FSM.
  - The FSM and counter stay in sum_accumulator.

Test Plan:
- Reset then in_sum=3,5,7,9, continuous in_valid, out_ready=1 -> out_valid one cycle after 4th accept; out_acc=24, out_ovf=0; in_ready low exactly one cycle.
- in_sum=31 x4 with default ACC_W=7 -> out_acc=124, out_ovf=0.
- ACC_W=6, in_sum=31 x4:
  - Without macro: out_acc=124 mod 64=60, out_ovf=1.
  - With ACC_SATURATE_EN: out_acc=63, out_ovf=1.
- Block ready, out_ready held 0 for 5 cycles while in_valid=1 -> out_acc stable, in_ready=0, no sums consumed; after out_ready=1, next block starts from acc=0.
- Gapped input: in_valid pattern 1,0,0,1,1,0,1 with sums 1,2,3,4 -> out_acc=10 after the 4th valid.
- rst_n asserted asynchronously after 2 accepts, then 4 sums of 2 -> out_acc=8; partial block discarded; out_valid=0 immediately during reset.
